// File: rtl/chip_path_pkg.sv
// Shared types and helpers for the chip_path trigger/selector slice.
package chip_path_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic MODE_PRIO = 1'b0;
  localparam logic MODE_MAX  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/chip_path_dly.sv
// Ring-buffer delay line holding all channels; tap is cfg_pre accepted samples old.
module chip_path_dly
  import chip_path_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int PW   = clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  input  logic [PW:0]      cfg_pre,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (adv) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_sys) begin
    if (adv) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  assign rd_ptr = wr_ptr_reg - cfg_pre[PW-1:0];
  assign dout   = (cfg_pre == '0) ? din : mem[rd_ptr];

endmodule

// File: rtl/chip_path_trig.sv
// Multi-channel threshold trigger: locks one channel and emits a framed
// burst of pre-trigger and post-trigger samples, then an optional holdoff.
module chip_path_trig
  import chip_path_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int DW        = 16,
  parameter int LENW      = 20,
  parameter int PRE_DEPTH = 16,
  parameter int SELW      = 7
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic [NCH*DW-1:0]         sm_data,
  input  logic                      sm_vld,
  input  logic                      buf_rdy,
  input  logic                      cfg_en,
  input  logic                      cfg_mode,
  input  logic [DW-1:0]             cfg_th,
  input  logic [LENW-1:0]           cfg_len,
  input  logic [clog2(PRE_DEPTH):0] cfg_pre,
  input  logic [15:0]               cfg_holdoff,
  output logic [DW-1:0]             d1_data,
  output logic                      d1_vld,
  output logic                      d1_sof,
  output logic                      d1_eof,
  output logic [SELW-1:0]           sel_path,
  output logic                      busy,
  output logic [15:0]               trig_cnt
);

  localparam int PW = clog2(PRE_DEPTH);

  state_t          state_reg, state_next;
  logic [LENW:0]   cnt_reg, cnt_next;
  logic [15:0]     hcnt_reg, hcnt_next;
  logic [PW:0]     fill_reg, fill_next;
  logic [SELW-1:0] sel_reg, sel_next;
  logic [15:0]     trig_reg, trig_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            vld_reg, sof_reg, eof_reg;

  logic [NCH*DW-1:0] tap;
  logic [DW-1:0]     ch     [NCH];
  logic [DW-1:0]     tap_ch [NCH];
  logic [NCH-1:0]    hit;

  logic            adv, trigger, emit, last;
  logic [LENW:0]   cnt_load, cnt_cur;
  logic [SELW-1:0] prio_idx, max_idx, cand_idx, sel_idx;
  logic [DW-1:0]   max_val, tap_sel;

  assign adv = sm_vld & buf_rdy;

  chip_path_dly #(
    .WIDTH(NCH*DW),
    .DEPTH(PRE_DEPTH)
  ) u_dly (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .adv    (adv),
    .din    (sm_data),
    .cfg_pre(cfg_pre),
    .dout   (tap)
  );

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch[gi]     = sm_data[gi*DW +: DW];
      assign tap_ch[gi] = tap[gi*DW +: DW];
      assign hit[gi]    = (ch[gi] >= cfg_th);
    end
  endgenerate

  // Priority pick scans downward so the lowest hit wins; argmax uses strict
  // greater-than so ties keep the lower index.
  always_comb begin
    prio_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (hit[k]) prio_idx = SELW'(k);
    end
    max_idx = '0;
    max_val = ch[0];
    for (int k = 1; k < NCH; k++) begin
      if (ch[k] > max_val) begin
        max_val = ch[k];
        max_idx = SELW'(k);
      end
    end
  end

  assign cand_idx = (cfg_mode == MODE_MAX) ? max_idx : prio_idx;
  assign trigger  = adv && (state_reg == ARMED) && cfg_en && (|hit) && (fill_reg >= cfg_pre);
  assign emit     = trigger || (adv && (state_reg == CAPTURE));
  assign cnt_load = (LENW+1)'(cfg_pre) + ((cfg_len == '0) ? (LENW+1)'(1) : {1'b0, cfg_len});
  assign cnt_cur  = trigger ? cnt_load : cnt_reg;
  assign last     = emit && (cnt_cur == (LENW+1)'(1));
  assign sel_idx  = trigger ? cand_idx : sel_reg;

  always_comb begin
    tap_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_idx == SELW'(k)) tap_sel = tap_ch[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hcnt_next  = hcnt_reg;
    fill_next  = fill_reg;
    sel_next   = sel_reg;
    trig_next  = trig_reg;
    data_next  = data_reg;

    if (emit) begin
      cnt_next  = cnt_cur - 1'b1;
      data_next = tap_sel;
    end
    if (trigger) begin
      sel_next = cand_idx;
      if (trig_reg != 16'hFFFF) trig_next = trig_reg + 1'b1;
    end

    if (adv) begin
      case (state_reg)
        IDLE:    if (cfg_en) state_next = ARMED;
        ARMED: begin
          if (!cfg_en)      state_next = IDLE;
          else if (trigger) state_next = CAPTURE;
        end
        HOLDOFF: begin
          if (!cfg_en)                 state_next = IDLE;
          else if (hcnt_reg < 16'd2)   state_next = ARMED;
          else                         hcnt_next  = hcnt_reg - 1'b1;
        end
        default: ;
      endcase

      // A frame never aborts; only its final word decides where to go next.
      if (last) begin
        if (cfg_holdoff != 16'd0) begin
          state_next = HOLDOFF;
          hcnt_next  = cfg_holdoff;
        end else begin
          state_next = cfg_en ? ARMED : IDLE;
        end
      end

      if (state_next == IDLE)                  fill_next = '0;
      else if (fill_reg != (PW+1)'(PRE_DEPTH)) fill_next = fill_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hcnt_reg  <= '0;
      fill_reg  <= '0;
      sel_reg   <= '0;
      trig_reg  <= '0;
      data_reg  <= '0;
      vld_reg   <= 1'b0;
      sof_reg   <= 1'b0;
      eof_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hcnt_reg  <= hcnt_next;
      fill_reg  <= fill_next;
      sel_reg   <= sel_next;
      trig_reg  <= trig_next;
      data_reg  <= data_next;
      vld_reg   <= emit;
      sof_reg   <= trigger;
      eof_reg   <= last;
    end
  end

  assign d1_data  = data_reg;
  assign d1_vld   = vld_reg;
  assign d1_sof   = sof_reg;
  assign d1_eof   = eof_reg;
  assign sel_path = sel_reg;
  assign trig_cnt = trig_reg;
  assign busy     = (state_reg == CAPTURE) || (state_reg == HOLDOFF);

endmodule

// File: tb/tb_chip_path_trig.sv
// Directed plus randomized bench for chip_path_trig against a sample-history model.
module tb_chip_path_trig;

  localparam int NCH       = 8;
  localparam int DW        = 16;
  localparam int LENW      = 20;
  localparam int PRE_DEPTH = 16;
  localparam int SELW      = 7;
  localparam int PREW      = 5;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NCH*DW-1:0] sm_data = '0;
  logic              sm_vld  = 1'b0;
  logic              buf_rdy = 1'b0;
  logic              cfg_en  = 1'b0;
  logic              cfg_mode = 1'b0;
  logic [DW-1:0]     cfg_th  = '0;
  logic [LENW-1:0]   cfg_len = '0;
  logic [PREW-1:0]   cfg_pre = '0;
  logic [15:0]       cfg_holdoff = '0;
  logic [DW-1:0]     d1_data;
  logic              d1_vld, d1_sof, d1_eof, busy;
  logic [SELW-1:0]   sel_path;
  logic [15:0]       trig_cnt;

  chip_path_trig #(
    .NCH(NCH), .DW(DW), .LENW(LENW), .PRE_DEPTH(PRE_DEPTH), .SELW(SELW)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .sm_data(sm_data), .sm_vld(sm_vld),
    .buf_rdy(buf_rdy), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_th(cfg_th),
    .cfg_len(cfg_len), .cfg_pre(cfg_pre), .cfg_holdoff(cfg_holdoff),
    .d1_data(d1_data), .d1_vld(d1_vld), .d1_sof(d1_sof), .d1_eof(d1_eof),
    .sel_path(sel_path), .busy(busy), .trig_cnt(trig_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame words are looked up in the full history of accepted samples.
  logic [NCH*DW-1:0] hist [$];
  int m_state;  // 0 idle, 1 armed, 2 capturing, 3 holdoff
  int m_fill, m_hcnt, m_sel, m_start, m_widx, m_total, m_trig;
  logic          exp_vld, exp_sof, exp_eof;
  logic [DW-1:0] exp_data;

  // Observation bookkeeping for directed checks
  logic [DW-1:0] obs_q [$];
  int cyc = 0, sof_cnt = 0, eof_cnt = 0, bad_emit = 0;
  int eof_cyc = -1, gap = -1, sof_first = -1;

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_hcnt = 0; m_sel = 0;
    m_start = 0; m_widx = 0; m_total = 0; m_trig = 0;
    exp_vld = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0; exp_data = '0;
  endtask

  function automatic bit model_pick(output int idx);
    int v, bestv;
    bit found;
    found = 1'b0; idx = 0; bestv = -1;
    for (int k = 0; k < NCH; k++) begin
      v = int'(sm_data[k*DW +: DW]);
      if (cfg_mode == 1'b0) begin
        if (!found && v >= int'(cfg_th)) begin idx = k; found = 1'b1; end
      end else if (v > bestv) begin
        bestv = v; idx = k;
      end
    end
    if (cfg_mode == 1'b1) found = (bestv >= int'(cfg_th));
    return found;
  endfunction

  task automatic model_adv();
    int n, pick;
    logic [NCH*DW-1:0] s;
    hist.push_back(sm_data);
    n = hist.size() - 1;
    exp_vld = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0;
    case (m_state)
      0: if (cfg_en) m_state = 1;
      1: begin
        if (!cfg_en) m_state = 0;
        else if (model_pick(pick) && m_fill >= int'(cfg_pre)) begin
          m_sel   = pick;
          m_start = n - int'(cfg_pre);
          m_widx  = 0;
          m_total = int'(cfg_pre) + ((cfg_len == 0) ? 1 : int'(cfg_len));
          if (m_trig < 65535) m_trig++;
          m_state = 2;
        end
      end
      3: begin
        if (!cfg_en) m_state = 0;
        else begin
          m_hcnt--;
          if (m_hcnt == 0) m_state = 1;
        end
      end
      default: ;
    endcase
    if (m_state == 2) begin
      s        = hist[m_start + m_widx];
      exp_vld  = 1'b1;
      exp_sof  = (m_widx == 0);
      exp_eof  = (m_widx == m_total - 1);
      exp_data = s[m_sel*DW +: DW];
      m_widx++;
      if (exp_eof) begin
        $display("[TB] frame ch=%0d words=%0d trig=%0d", m_sel, m_total, m_trig);
        if (cfg_holdoff != 0) begin m_state = 3; m_hcnt = int'(cfg_holdoff); end
        else m_state = cfg_en ? 1 : 0;
      end
    end
    if (m_state == 0)              m_fill = 0;
    else if (m_fill < PRE_DEPTH)   m_fill++;
  endtask

  task automatic step();
    @(posedge clk_sys);
    cyc++;
    if (rst_n && sm_vld && buf_rdy) model_adv();
    else begin exp_vld = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0; end
    #1;
    check_eq("vld",  32'(d1_vld),   32'(exp_vld));
    check_eq("sof",  32'(d1_sof),   32'(exp_sof));
    check_eq("eof",  32'(d1_eof),   32'(exp_eof));
    check_eq("data", 32'(d1_data),  32'(exp_data));
    check_eq("sel",  32'(sel_path), 32'(m_sel));
    check_eq("busy", 32'(busy),     32'(m_state == 2 || m_state == 3));
    check_eq("trig", 32'(trig_cnt), 32'(m_trig));
    if (d1_vld) obs_q.push_back(d1_data);
    if (d1_vld && !buf_rdy) bad_emit++;
    if (d1_sof) begin
      sof_cnt++;
      if (sof_first < 0) sof_first = cyc;
      if (eof_cyc >= 0 && gap < 0) gap = cyc - eof_cyc;
    end
    if (d1_eof) begin eof_cnt++; eof_cyc = cyc; end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    sm_data[k*DW +: DW] = v;
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int k = 0; k < NCH; k++) set_ch(k, v);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    sof_cnt = 0; eof_cnt = 0; bad_emit = 0;
    eof_cyc = -1; gap = -1; sof_first = -1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int tb_trig, rel, waited;
    model_reset();
    run(3);  // reset held: every output must read zero
    rst_n = 1'b1;

    // Priority mode, lowest of two equal crossings
    cfg_mode = 1'b0; cfg_th = 16'h100; cfg_pre = 0; cfg_len = 4; cfg_holdoff = 0;
    sm_vld = 1'b1; buf_rdy = 1'b1; set_all(16'h10); cfg_en = 1'b1;
    run(3);
    clear_obs();
    set_ch(2, 16'h200); set_ch(5, 16'h200);
    step();
    check_eq("s1_sof_first", 32'(d1_sof), 32'd1);
    check_eq("s1_sel", 32'(sel_path), 32'd2);
    set_all(16'h10);
    run(4);
    check_eq("s1_words", 32'(obs_q.size()), 32'd4);
    check_eq("s1_w0", 32'(obs_q[0]), 32'h200);
    check_eq("s1_w3", 32'(obs_q[3]), 32'h10);
    check_eq("s1_eofs", 32'(eof_cnt), 32'd1);

    // Max-amplitude mode and its tie rule
    cfg_en = 1'b0; step(); cfg_mode = 1'b1; cfg_en = 1'b1; run(2);
    set_ch(2, 16'h200); set_ch(5, 16'h300); step();
    check_eq("s2_sel_max", 32'(sel_path), 32'd5);
    set_all(16'h10); run(4);
    set_ch(2, 16'h300); set_ch(5, 16'h300); step();
    check_eq("s2_sel_tie", 32'(sel_path), 32'd2);
    set_all(16'h10); run(4);

    // Pre-trigger samples from a ramp on channel 0
    cfg_en = 1'b0; step();
    cfg_mode = 1'b0; cfg_pre = 3; cfg_len = 2; cfg_th = 16'd10; set_all(16'h0); cfg_en = 1'b1;
    clear_obs();
    for (int v = 1; v <= 11; v++) begin set_ch(0, DW'(v)); step(); end
    set_ch(0, 16'h0); run(6);
    check_eq("s3_words", 32'(obs_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) check_eq("s3_ramp", 32'(obs_q[i]), 32'(7 + i));
    cfg_en = 1'b0; step(); cfg_en = 1'b1;
    tb_trig = int'(trig_cnt);
    set_ch(0, 16'd1); step(); set_ch(0, 16'd2); step(); set_ch(0, 16'd200); step();
    check_eq("s3_early_busy", 32'(busy), 32'd0);
    set_ch(0, 16'h0); run(2);
    check_eq("s3_early_trig", 32'(trig_cnt), 32'(tb_trig));

    // Backpressure and a second crossing mid-frame
    pulse_reset();
    cfg_pre = 0; cfg_len = 5; cfg_th = 16'h100; cfg_holdoff = 0; set_all(16'h10); cfg_en = 1'b1;
    run(3);
    clear_obs();
    for (int i = 0; i < 15; i++) begin
      buf_rdy = (i % 3 == 0);
      set_all(16'h10);
      if (i == 0) set_ch(1, 16'h150);
      if (i == 6) set_ch(3, 16'h400);
      step();
    end
    buf_rdy = 1'b1; set_all(16'h10); run(3);
    check_eq("s4_words", 32'(obs_q.size()), 32'd5);
    check_eq("s4_w0", 32'(obs_q[0]), 32'h150);
    check_eq("s4_stall_emit", 32'(bad_emit), 32'd0);
    check_eq("s4_trig", 32'(trig_cnt), 32'd1);

    // Holdoff spacing, then disabling mid-frame
    cfg_en = 1'b0; step();
    cfg_holdoff = 3; cfg_th = 16'h0; cfg_len = 2; cfg_pre = 0; cfg_en = 1'b1;
    clear_obs();
    run(20);
    check_eq("s5_gap", 32'(gap), 32'd4);
    cfg_en = 1'b0; run(8);
    cfg_len = 6; cfg_holdoff = 0; cfg_th = 16'h100; set_all(16'h10); cfg_en = 1'b1;
    run(2);
    clear_obs();
    set_ch(4, 16'h180); step(); set_all(16'h10); run(2);
    cfg_en = 1'b0; set_all(16'h200); run(8);
    check_eq("s5_words", 32'(obs_q.size()), 32'd6);
    check_eq("s5_sofs", 32'(sof_cnt), 32'd1);
    check_eq("s5_idle", 32'(busy), 32'd0);
    check_eq("s5_sel", 32'(sel_path), 32'd4);

    // Asynchronous reset in the middle of a frame
    cfg_len = 20; cfg_pre = 4; cfg_th = 16'h100; set_all(16'h10); cfg_en = 1'b1;
    run(6);
    set_ch(6, 16'h300); step();
    check_eq("s6_sel", 32'(sel_path), 32'd6);
    set_all(16'h10); run(5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("s6_rst_vld", 32'(d1_vld), 32'd0);
    check_eq("s6_rst_sel", 32'(sel_path), 32'd0);
    check_eq("s6_rst_busy", 32'(busy), 32'd0);
    check_eq("s6_rst_trig", 32'(trig_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    set_ch(6, 16'h300);
    clear_obs();
    rel = cyc;
    run(8);
    check_eq("s6_refill", 32'(sof_first - rel), 32'd5);
    check_eq("s6_trig", 32'(trig_cnt), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (i % 150 == 0) begin
        cfg_en = 1'b0; sm_vld = 1'b1; buf_rdy = 1'b1;
        waited = 0;
        while (m_state != 0 && waited < 100) begin step(); waited++; end
        check_eq("idle_wait", 32'(m_state), 32'd0);
        cfg_mode = 1'($urandom_range(0, 1));
        cfg_pre  = PREW'($urandom_range(0, PRE_DEPTH - 1));
        cfg_len  = LENW'($urandom_range(0, 12));
        cfg_en   = 1'b1;
      end
      if (i % 40 == 0) begin
        cfg_th = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(256, 65535));
        cfg_holdoff = 16'($urandom_range(0, 4));
      end
      if (i == 1200) pulse_reset();
      sm_vld  = ($urandom_range(0, 9) < 8);
      buf_rdy = ($urandom_range(0, 9) < 8);
      for (int k = 0; k < NCH; k++) begin
        case ($urandom_range(0, 15))
          0:       set_ch(k, DW'($urandom_range(0, 65535)));
          1:       set_ch(k, 16'h8000);
          default: set_ch(k, DW'($urandom_range(0, 255)));
        endcase
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
